// File: rtl/fp_mult_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mult (helper) / fp_mult_sched (top)
//  Purpose  : Shares one single-precision multiplier among NREQ requesters.
//             A round-robin arbiter accepts at most one operand pair per
//             cycle. Credit-based flow control makes sure every product that
//             enters the fixed-latency pipeline has a slot reserved in the
//             result FIFO.
//  Ports    : clk, rst                 clock / synchronous active-high reset
//             req_valid/req_ready      per-requester issue handshake
//             req_a/req_b              packed operands, requester i at [32*i+:32]
//             rsp_valid/rsp_ready      response handshake (FIFO head)
//             rsp_id/rsp_product       tag and product of the head result
//             busy                     any operation in pipeline or FIFO
//  Revision : 1.0  initial release
// ============================================================================

// Truncating IEEE-754 single multiplier. It has no special-case handling
// (zero, denormal, Inf, NaN), and the exponent simply wraps.
module fp_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [47:0] w_mp;
    logic [9:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_unused_bits;

    assign w_ma  = {1'b1, a[22:0]};
    assign w_mb  = {1'b1, b[22:0]};
    assign w_mp  = 48'(w_ma) * 48'(w_mb);
    // The significand product lies in [1,4). If bit 47 is set, the result
    // is normalised one place further and the exponent goes up by one.
    assign w_exp = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127
                 + {9'd0, w_mp[47]};
    assign w_frac = w_mp[47] ? w_mp[46:24] : w_mp[45:23];
    assign product = {a[31] ^ b[31], w_exp[7:0], w_frac};

    assign w_unused_bits = ^{w_exp[9:8], w_mp[22:0]};
endmodule

module fp_mult_sched #(
    parameter int NREQ       = 4,
    parameter int PIPE       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [32*NREQ-1:0]        req_a,
    input  logic [32*NREQ-1:0]        req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [31:0]               rsp_product,
    output logic                      busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = $clog2(PIPE + FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0] r_ptr;
    logic [PIPE-1:0] r_stg_vld;
    logic [31:0]    r_stg_prod [PIPE];
    logic [IDW-1:0] r_stg_id   [PIPE];
    logic [31:0]    r_mem_prod [FIFO_DEPTH];
    logic [IDW-1:0] r_mem_id   [FIFO_DEPTH];
    logic [FAW-1:0] r_wr;
    logic [FAW-1:0] r_rd;
    logic [CW-1:0]  r_count;

    // ------------------------------------------------------------------
    // Credit: the in-flight stage count plus the FIFO occupancy, taken from
    // registered state only. A pop returns its credit one cycle later.
    // ------------------------------------------------------------------
    logic [OW-1:0] w_outst;
    always_comb begin
        w_outst = OW'(r_count);
        for (int k = 0; k < PIPE; k++) begin
            w_outst = w_outst + OW'(r_stg_vld[k]);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: the first valid requester found scanning from r_ptr
    // ------------------------------------------------------------------
    logic           w_found;
    logic [IDW-1:0] w_grant;
    int             w_scan;
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = IDW'(w_scan);
            end
        end
    end

    logic           w_issue;
    logic [IDW-1:0] w_ptr_nxt;
    logic [31:0]    w_a;
    logic [31:0]    w_b;
    logic [31:0]    w_prod;

    assign w_issue   = w_found && (w_outst < OW'(FIFO_DEPTH)) && !rst;
    assign req_ready = w_issue ? (NREQ'(1) << w_grant) : '0;
    assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
    assign w_a       = req_a[32*int'(w_grant) +: 32];
    assign w_b       = req_b[32*int'(w_grant) +: 32];

    fp_mult u_fp_mult (
        .a       (w_a),
        .b       (w_b),
        .product (w_prod)
    );

    // ------------------------------------------------------------------
    // Fixed-latency pipeline. It never stalls, because credit reserves a
    // FIFO slot for every product before it enters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_stg_vld <= '0;
        end else begin
            if (w_issue) begin
                r_ptr <= w_ptr_nxt;
            end
            r_stg_vld[0] <= w_issue;
            for (int k = 1; k < PIPE; k++) begin
                r_stg_vld[k] <= r_stg_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_stg_prod[0] <= w_prod;
        r_stg_id[0]   <= w_grant;
        for (int k = 1; k < PIPE; k++) begin
            r_stg_prod[k] <= r_stg_prod[k-1];
            r_stg_id[k]   <= r_stg_id[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic w_push;
    logic w_pop;

    assign w_push    = r_stg_vld[PIPE-1];
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    function automatic logic [FAW-1:0] f_inc(input logic [FAW-1:0] p);
        return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_prod[r_wr] <= r_stg_prod[PIPE-1];
            r_mem_id[r_wr]   <= r_stg_id[PIPE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= f_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_inc(r_rd);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign rsp_id      = rsp_valid ? r_mem_id[r_rd]   : '0;
    assign rsp_product = rsp_valid ? r_mem_prod[r_rd] : '0;
    assign busy        = (w_outst != '0);
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mult_sched
//  Purpose  : Directed, self-checking bench for fp_mult_sched. It applies
//             single-issue product vectors from a table, followed by
//             hand-written multi-cycle sequences for arbitration, credit
//             and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mult_sched;
    localparam int NREQ       = 4;
    localparam int PIPE       = 2;
    localparam int FIFO_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_product;
    logic         busy;

    fp_mult_sched #(.NREQ(NREQ), .PIPE(PIPE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] bvals [4];
    logic [31:0] pexp  [4];
    int          exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int got;
        int e;
        int resumed;

        vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000}; // 2*3
        vecs[1] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000}; // 1.5*1.5
        vecs[2] = '{1, 32'h3F800000, 32'h3F800000, 32'h3F800000}; // 1*1
        vecs[3] = '{3, 32'hC0000000, 32'h40400000, 32'hC0C00000}; // -2*3
        vecs[4] = '{1, 32'h3FC00000, 32'hBFC00000, 32'hC0100000}; // 1.5*-1.5
        vecs[5] = '{3, 32'h40800000, 32'h3F000000, 32'h40000000}; // 4*0.5
        vecs[6] = '{2, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE}; // truncated
        bvals = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3F000000};
        pexp  = '{32'h40000000, 32'h40C00000, 32'h40400000, 32'h3F800000};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset behaviour
        @(negedge clk); req_valid = 4'hF; #1;
        chk("ready_in_rst", req_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; req_valid = '0; #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_busy", busy, 0);

        // Table-driven single issues: grant, latency, tag and product
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            req_valid = 4'b0001 << vecs[v].idx;
            req_a[32*vecs[v].idx +: 32] = vecs[v].a;
            req_b[32*vecs[v].idx +: 32] = vecs[v].b;
            #1 chk("vec_ready", req_ready, 4'b0001 << vecs[v].idx);
            @(negedge clk); req_valid = '0; #1;
            chk("vec_lat0", rsp_valid, 0);
            @(negedge clk); #1;
            chk("vec_lat1", rsp_valid, 0);
            @(negedge clk); #1;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_id", rsp_id, vecs[v].idx);
            chk("vec_product", rsp_product, vecs[v].p);
            @(negedge clk); #1;
            chk("vec_idle", busy, 0);
        end

        // Continuous issue from all requesters, with no bubbles
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h40000000;
            req_b[32*i +: 32] = bvals[i];
        end
        issued = 0; got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            req_valid = (issued < 8) ? 4'hF : 4'h0;
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("t3_extra_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("t3_rsp_id", rsp_id, e);
                    chk("t3_product", rsp_product, pexp[e]);
                    got++;
                end
            end
            if (issued < 8) begin
                chk("t3_grant", req_ready, 4'b0001 << (issued % 4));
                exp_q.push_back(issued % 4);
                issued++;
            end
        end
        chk("t3_rsp_count", got, 8);

        // Credit limit with a stalled consumer (ptr is back at 0)
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req_valid = 4'hF; #1;
            chk("t4_grant", req_ready, 4'b0001 << k);
        end
        repeat (3) begin
            @(negedge clk); #1;
            chk("t4_no_credit", req_ready, 0);
            chk("t4_busy", busy, 1);
            chk("t4_head_id", rsp_id, 0);
        end
        got = 0; resumed = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk); rsp_ready = 1'b1; #1;
            if (cyc == 0) chk("t4_credit_lag", req_ready, 0);
            if (rsp_valid && got < 4) begin
                chk("t4_rsp_id", rsp_id, got);
                chk("t4_product", rsp_product, pexp[got]);
                got++;
            end
            if (resumed == 0 && req_ready != 0) begin
                resumed = 1;
                chk("t4_resume_grant", req_ready, 4'b0001);
            end
        end
        chk("t4_rsp_count", got, 4);
        chk("t4_resumed", resumed, 1);
        @(negedge clk); req_valid = '0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
        #1 chk("t4_drained", busy, 0);

        // Round-robin skip and wrap
        @(negedge clk); req_valid = 4'b0100; #1;
        chk("t5_grant2", req_ready, 4'b0100);
        @(negedge clk); req_valid = 4'b1010; #1;
        chk("t5_grant3", req_ready, 4'b1000);
        @(negedge clk); #1;
        chk("t5_grant1", req_ready, 4'b0010);
        @(negedge clk); req_valid = '0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
        #1 chk("t5_drained", busy, 0);

        // Reset with three operations in flight (ptr is at 2)
        rsp_ready = 1'b0;
        @(negedge clk); req_valid = 4'hF; #1;
        chk("t6_grant2", req_ready, 4'b0100);
        @(negedge clk); #1;
        chk("t6_grant3", req_ready, 4'b1000);
        @(negedge clk); #1;
        chk("t6_grant0", req_ready, 4'b0001);
        @(negedge clk); rst = 1'b1; #1;
        chk("t6_ready_in_rst", req_ready, 0);
        chk("t6_busy_before", busy, 1);
        @(negedge clk); rst = 1'b0; req_valid = '0; rsp_ready = 1'b1; #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk); #1;
            chk("t6_no_stale", rsp_valid, 0);
        end
        @(negedge clk); req_valid = 4'hF; #1;
        chk("t6_grant_after_rst", req_ready, 4'b0001);
        @(negedge clk); req_valid = '0;
        got = 0;
        for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
            #1;
            if (rsp_valid) begin
                chk("t6_rsp_id", rsp_id, 0);
                chk("t6_product", rsp_product, 32'h40000000);
                got = 1;
            end
            @(negedge clk);
        end
        chk("t6_rsp_seen", got, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
